seq_gen_1011: RTL and testbench

- Serial pattern transmitter; the stimulus-side counterpart of the 1011 sequence detector.
- On a start request it emits a programmable PAT_W-bit pattern (default 1011), MSB first, one bit per clock.
- The pattern repeats a requested number of times, with an optional idle gap between repetitions.
- Its serial output drives the detector's `in` port directly, so detection can be checked in-system.

---
 rtl/seq_gen_1011_pkg.sv | 15 +
 rtl/seq_gen_1011_if.sv | 39 +++
 rtl/seq_gen_1011.sv | 147 ++++++++++++++
 tb/tb_seq_gen_1011.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_1011_pkg.sv
// Shared definitions for the 1011 pattern generator and the detector side,
// so both ends of the link agree on the pattern and the FSM encoding.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        FIN
    } seq_state_e;

    localparam int PAT_W_DEFAULT = 4;
    localparam logic [PAT_W_DEFAULT-1:0] SEQ_1011 = 4'b1011;

endpackage

// File: rtl/seq_gen_1011_if.sv
// Request/serial-stream bundle between a burst requester and seq_gen_1011.
// The slave modport is the generator's view of the bundle.
interface seq_gen_1011_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);

    logic             start;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             out;
    logic             valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output repeat_cnt,
        output gap,
        input  out,
        input  valid,
        input  frame_start,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  repeat_cnt,
        input  gap,
        output out,
        output valid,
        output frame_start,
        output busy,
        output done
    );

endinterface

// File: rtl/seq_gen_1011.sv
// Serial pattern transmitter: sends PATTERN MSB first, repeat_cnt times,
// with gap idle cycles between frames. Every output is a flop.
module seq_gen_1011
    import seq_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_1011),
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    seq_gen_1011_if.slave  bus
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    seq_state_e       state_q,       state_d;
    logic [PAT_W-1:0] shift_q,       shift_d;
    logic [BIT_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic [CNT_W-1:0] frames_left_q, frames_left_d;
    logic [GAP_W-1:0] gap_reg_q,     gap_reg_d;
    logic [GAP_W-1:0] gap_cnt_q,     gap_cnt_d;
    logic             out_q,         out_d;
    logic             valid_q,       valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;

    // Outputs are computed for the cycle being entered, then registered.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        frames_left_d = frames_left_q;
        gap_reg_d     = gap_reg_q;
        gap_cnt_d     = gap_cnt_q;
        valid_d       = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.repeat_cnt != '0) begin
                        state_d       = SEND;
                        frames_left_d = bus.repeat_cnt;
                        gap_reg_d     = bus.gap;
                        shift_d       = PATTERN;
                        bit_cnt_d     = '0;
                        valid_d       = 1'b1;
                        frame_start_d = 1'b1;
                        busy_d        = 1'b1;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end

            SEND: begin
                busy_d = 1'b1;
                if (bit_cnt_q != LAST_BIT) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    valid_d   = 1'b1;
                end else begin
                    frames_left_d = frames_left_q - 1'b1;
                    if (frames_left_d == '0) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (gap_reg_q == '0) begin
                        shift_d       = PATTERN;
                        bit_cnt_d     = '0;
                        valid_d       = 1'b1;
                        frame_start_d = 1'b1;
                    end else begin
                        // Entering GAP already spends one of the gap cycles.
                        state_d   = GAP;
                        gap_cnt_d = gap_reg_q - 1'b1;
                    end
                end
            end

            GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == '0) begin
                    state_d       = SEND;
                    shift_d       = PATTERN;
                    bit_cnt_d     = '0;
                    valid_d       = 1'b1;
                    frame_start_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        out_d = valid_d & shift_d[PAT_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frames_left_q <= '0;
            gap_reg_q     <= '0;
            gap_cnt_q     <= '0;
            out_q         <= 1'b0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            frames_left_q <= frames_left_d;
            gap_reg_q     <= gap_reg_d;
            gap_cnt_q     <= gap_cnt_d;
            out_q         <= out_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.valid       = valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_gen_1011.sv
// Bench for seq_gen_1011: a queue-based burst model checked every cycle,
// plus directed bursts whose results are pinned to hand-computed values.
module tb_seq_gen_1011;
    import seq_pkg::*;

    localparam int PAT_W = PAT_W_DEFAULT;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
    localparam logic [PAT_W-1:0] PAT = SEQ_1011;

    typedef struct packed {
        logic out;
        logic valid;
        logic fs;
        logic busy;
        logic done;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seq_gen_1011_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    seq_gen_1011 #(
        .PAT_W   (PAT_W),
        .PATTERN (PAT),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    obs_t cur_exp    = '0;
    bit   model_live = 1'b0;

    // Whole burst is laid out as a list of per-cycle observations up front.
    function automatic void plan_burst(input int n, input int g);
        obs_t e;
        logic [PAT_W-1:0] p;
        p = PAT;
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < PAT_W; b++) begin
                e       = '0;
                e.valid = 1'b1;
                e.out   = p[PAT_W-1-b];
                e.fs    = (b == 0);
                e.busy  = 1'b1;
                exp_q.push_back(e);
            end
            if (f < n - 1) begin
                for (int k = 0; k < g; k++) begin
                    e      = '0;
                    e.busy = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
        e      = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endfunction

    // A request is honoured only when nothing is pending and the cycle just shown was quiet.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_exp    = '0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (exp_q.size() == 0 && cur_exp == '0 && bus.start)
                plan_burst(int'(bus.repeat_cnt), int'(bus.gap));
            if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
            else                   cur_exp = '0;
        end
    end

    always @(negedge clk) begin : compare_proc
        obs_t act;
        if (model_live) begin
            act = {bus.out, bus.valid, bus.frame_start, bus.busy, bus.done};
            checks++;
            if (act !== cur_exp) begin
                errors++;
                $display("[TB] FAIL cycle_outputs t=%0t actual=%b required=%b (out,valid,frame_start,busy,done)",
                         $time, act, cur_exp);
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Launches one burst and records what appears until done or the cycle budget runs out.
    task automatic applyStimulus(input int n, input int g, input int restart_at, input int max_cycles,
                                 output logic [63:0] bits, output int nbits, output int busy_cycles,
                                 output int done_k, output bit got_done);
        bits        = '0;
        nbits       = 0;
        busy_cycles = 0;
        done_k      = -1;
        got_done    = 1'b0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.repeat_cnt = CNT_W'(n);
        bus.gap        = GAP_W'(g);
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            bus.start = (k == restart_at);
            if (k == restart_at) begin
                bus.repeat_cnt = CNT_W'(7);
                bus.gap        = GAP_W'(5);
            end
            if (bus.valid) begin
                bits = {bits[62:0], bus.out};
                nbits++;
            end
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                done_k   = k;
                got_done = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    function automatic logic [63:0] match_ends(input logic [63:0] bits, input int nbits);
        logic [63:0] mask;
        mask = '0;
        for (int p = PAT_W; p <= nbits; p++)
            if (bits[(nbits - p) +: PAT_W] == PAT) mask[p] = 1'b1;
        return mask;
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] bits;
        int nbits, busy_cycles, done_k, cnt;
        bit got_done;

        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.repeat_cnt = CNT_W'(1);
        bus.gap        = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {bus.out, bus.valid, bus.frame_start, bus.busy, bus.done}, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid || bus.busy || bus.done) cnt++;
        end
        checkOutput("no_burst_after_reset", cnt, 0);

        applyStimulus(1, 0, 0, 50, bits, nbits, busy_cycles, done_k, got_done);
        checkOutput("single_bits", bits, 64'hB);
        checkOutput("single_nbits", nbits, 4);
        checkOutput("single_busy", busy_cycles, 4);
        checkOutput("single_done_k", done_k, 5);

        bus.start      = 1'b1;
        bus.repeat_cnt = CNT_W'(1);
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid) cnt++;
        end
        checkOutput("start_in_fin_ignored", cnt, 0);

        applyStimulus(3, 0, 0, 50, bits, nbits, busy_cycles, done_k, got_done);
        checkOutput("b2b_bits", bits, 64'hBBB);
        checkOutput("b2b_nbits", nbits, 12);
        checkOutput("b2b_detect_ends", match_ends(bits, nbits), 64'h1110);
        checkOutput("b2b_done_k", done_k, 13);

        applyStimulus(2, 3, 0, 50, bits, nbits, busy_cycles, done_k, got_done);
        checkOutput("gap_bits", bits, 64'hBB);
        checkOutput("gap_busy", busy_cycles, 11);
        checkOutput("gap_done_k", done_k, 12);

        applyStimulus(0, 2, 0, 50, bits, nbits, busy_cycles, done_k, got_done);
        checkOutput("zero_done_k", done_k, 1);
        checkOutput("zero_nbits", nbits, 0);
        checkOutput("zero_busy", busy_cycles, 0);

        applyStimulus(2, 0, 3, 50, bits, nbits, busy_cycles, done_k, got_done);
        checkOutput("restart_bits", bits, 64'hBB);
        checkOutput("restart_nbits", nbits, 8);
        checkOutput("restart_done_k", done_k, 9);

        applyStimulus(255, 1, 0, 2000, bits, nbits, busy_cycles, done_k, got_done);
        checkOutput("max_got_done", got_done, 1);
        checkOutput("max_nbits", nbits, 1020);
        checkOutput("max_done_k", done_k, 1275);

        @(negedge clk);
        bus.start      = 1'b1;
        bus.repeat_cnt = CNT_W'(2);
        bus.gap        = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midburst_reset_outputs", {bus.out, bus.valid, bus.frame_start, bus.busy, bus.done}, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done || bus.valid) cnt++;
        end
        checkOutput("midburst_no_done", cnt, 0);
        applyStimulus(1, 0, 0, 50, bits, nbits, busy_cycles, done_k, got_done);
        checkOutput("after_reset_bits", bits, 64'hB);

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst            = ($urandom_range(0, 199) == 0);
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.repeat_cnt = CNT_W'($urandom_range(0, 4));
            bus.gap        = GAP_W'($urandom_range(0, 3));
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
